// File: rtl/mips_cpu_muldiv_unit.sv
// mips_cpu_muldiv_unit: iterative HI/LO multiply/divide unit for the MIPS datapath.
// It owns the HI and LO registers. MULT/MULTU/DIV/DIVU run for WIDTH/BITS_PER_CYCLE
// iterate cycles followed by one FIX cycle. MTHI/MTLO complete in a single edge.
module mips_cpu_muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  // r_acc: product upper half / partial remainder.
  // r_q: multiplier shifting out / quotient shifting in.
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  // r_a: multiplicand or divisor magnitude.
  logic [WIDTH-1:0]   r_a;
  // Raw dividend, returned in HI on divide by zero.
  logic [WIDTH-1:0]   r_rs_raw;
  logic               r_is_div;
  logic               r_div_zero;
  logic               r_neg_res;
  logic               r_neg_rem;

  // Request decode
  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_signed;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;

  // One iteration worth of BITS_PER_CYCLE steps
  logic [WIDTH-1:0]   w_mul_acc;
  logic [WIDTH-1:0]   w_mul_q;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_div_rem;
  logic [WIDTH-1:0]   w_div_q;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;

  // Sign fix-up of the finished magnitudes
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_accept    = start && (r_state == ST_IDLE);
  assign w_is_mul    = (func == FN_MULT) || (func == FN_MULTU);
  assign w_is_div    = (func == FN_DIV)  || (func == FN_DIVU);
  assign w_is_signed = (func == FN_MULT) || (func == FN_DIV);
  assign w_rs_neg    = w_is_signed && rs_data[WIDTH-1];
  assign w_rt_neg    = w_is_signed && rt_data[WIDTH-1];
  assign w_rs_mag    = w_rs_neg ? -rs_data : rs_data;
  assign w_rt_mag    = w_rt_neg ? -rt_data : rt_data;

  assign w_prod      = {r_acc, r_q};
  assign w_prod_fix  = r_neg_res ? -w_prod : w_prod;
  assign w_quo       = r_neg_res ? -r_q : r_q;
  assign w_rem       = r_neg_rem ? -r_acc : r_acc;

  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

  // Unrolled shift-add and restoring-division steps for one iterate cycle
  always_comb begin
    w_mul_acc   = r_acc;
    w_mul_q     = r_q;
    w_mul_sum   = '0;
    w_div_rem   = r_acc;
    w_div_q     = r_q;
    w_div_shift = '0;
    w_div_diff  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      // Add the multiplicand when the current multiplier bit is set, then shift right.
      w_mul_sum = {1'b0, w_mul_acc} + {1'b0, (w_mul_q[0] ? r_a : {WIDTH{1'b0}})};
      w_mul_acc = w_mul_sum[WIDTH:1];
      w_mul_q   = {w_mul_sum[0], w_mul_q[WIDTH-1:1]};
      // Bring in the next dividend bit and keep the difference when it does not borrow.
      w_div_shift = {w_div_rem, w_div_q[WIDTH-1]};
      w_div_diff  = w_div_shift - {1'b0, r_a};
      if (w_div_diff[WIDTH]) begin
        w_div_rem = w_div_shift[WIDTH-1:0];
      end else begin
        w_div_rem = w_div_diff[WIDTH-1:0];
      end
      w_div_q = {w_div_q[WIDTH-2:0], ~w_div_diff[WIDTH]};
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> MUL/DIV -> (N iterations) -> FIX -> IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_next = ST_MUL;
        end else if (w_accept && w_is_div) begin
          w_state_next = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == CNT_W'(N - 1)) begin
          w_state_next = ST_FIX;
        end
      end
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO writeback and done pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_acc      <= '0;
      r_q        <= '0;
      r_a        <= '0;
      r_rs_raw   <= '0;
      r_is_div   <= 1'b0;
      r_div_zero <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (func == FN_MTHI) begin
              r_hi <= rs_data;
            end
            if (func == FN_MTLO) begin
              r_lo <= rs_data;
            end
            if (w_is_mul || w_is_div) begin
              r_cnt      <= '0;
              r_acc      <= '0;
              r_is_div   <= w_is_div;
              r_rs_raw   <= rs_data;
              r_div_zero <= w_is_div && (rt_data == '0);
              r_neg_rem  <= w_is_div && w_rs_neg;
              if (w_is_div) begin
                r_a       <= w_rt_mag;
                r_q       <= w_rs_mag;
                // A zero divisor keeps the all-ones quotient unnegated.
                r_neg_res <= (w_rs_neg ^ w_rt_neg) && (rt_data != '0);
              end else begin
                r_a       <= w_rs_mag;
                r_q       <= w_rt_mag;
                r_neg_res <= w_rs_neg ^ w_rt_neg;
              end
            end
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_acc;
          r_q   <= w_mul_q;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_DIV: begin
          r_acc <= w_div_rem;
          r_q   <= w_div_q;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            if (r_div_zero) begin
              r_hi <= r_rs_raw;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
